alarm_trigger: RTL and testbench

Decides when the alarm sounds. It compares the running clock time against the stored alarm time, holds the ring for a bounded duration and handles snooze and stop requests. Its `ring` output drives the enable input of the downstream LED-flash stage. It sits between the timekeeping/alarm-setting registers and the flash/buzzer output stages.

---
 rtl/alarm_pkg.sv | 19 +
 rtl/sec_down_timer.sv | 37 +++
 rtl/alarm_trigger.sv | 137 +++++++++++++
 tb/tb_alarm_trigger.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared widths and FSM encoding for the alarm trigger block.
package alarm_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2,
    StLockout = 2'd3
  } alarm_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sec_down_timer.sv
// Seconds down-counter shared by the ring and snooze periods; expire pulses
// on the sec_tick that consumes the last remaining second.
module sec_down_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             sec_tick,
  output logic             expire
);

  logic [Width-1:0] count_q, count_d;

  // A load wins over a coincident tick, so the loaded value is used in full.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && sec_tick && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && sec_tick && (count_q == Width'(1));

endmodule

// File: rtl/alarm_trigger.sv
// Alarm ring/snooze/stop controller. Snooze support is built only when the
// ALARM_SNOOZE_EN macro is defined; otherwise snooze is ignored.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3,
  localparam int unsigned CNT_W      = $clog2(MAX_SNOOZE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_tick,
  input  logic [HOUR_W-1:0] hours,
  input  logic [MIN_W-1:0]  minutes,
  input  logic [SEC_W-1:0]  seconds,
  input  logic [HOUR_W-1:0] alarm_hours,
  input  logic [MIN_W-1:0]  alarm_minutes,
  input  logic              alarm_on,
  input  logic              snooze,
  input  logic              stop,
  output logic              ring,
  output logic              snoozing,
  output logic [CNT_W-1:0]  snooze_count,
  output logic [1:0]        state_o
);

  localparam int unsigned TIMER_W = $clog2(max_u(RING_SECS, SNOOZE_SECS) + 1);

`ifdef ALARM_SNOOZE_EN
  localparam bit SnoozeEn = 1'b1;
`else
  localparam bit SnoozeEn = 1'b0;
`endif

  alarm_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ring_q, ring_d;
  logic               snoozing_q, snoozing_d;
  logic               match;
  logic               snooze_req;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_en;
  logic               expire;

  assign match = alarm_on && (hours == alarm_hours) && (minutes == alarm_minutes)
                 && (seconds == '0);
  assign snooze_req = SnoozeEn && snooze;
  assign tmr_en     = (state_q == StRinging) || (state_q == StSnooze);

  sec_down_timer #(
    .Width(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .en        (tmr_en),
    .load      (tmr_load),
    .load_value(tmr_value),
    .sec_tick  (sec_tick),
    .expire    (expire)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_load  = 1'b0;
    tmr_value = TIMER_W'(RING_SECS);
    // Disarm overrides every other request in every state.
    if (!alarm_on) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (match) begin
            state_d  = StRinging;
            tmr_load = 1'b1;
            cnt_d    = '0;
          end
        end
        StRinging: begin
          if (stop) begin
            state_d = StLockout;
          end else if (snooze_req && (cnt_q < CNT_W'(MAX_SNOOZE))) begin
            state_d   = StSnooze;
            tmr_load  = 1'b1;
            tmr_value = TIMER_W'(SNOOZE_SECS);
            cnt_d     = cnt_q + CNT_W'(1);
          end else if (expire) begin
            state_d = StLockout;
          end
        end
        StSnooze: begin
          if (stop) begin
            state_d = StLockout;
          end else if (expire) begin
            state_d  = StRinging;
            tmr_load = 1'b1;
          end
        end
        StLockout: begin
          // Hold until the matching 00 second has passed to avoid re-trigger.
          if (!match) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ring_d     = (state_d == StRinging);
    snoozing_d = SnoozeEn && (state_d == StSnooze);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ring_q     <= ring_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign ring         = ring_q;
  assign snoozing     = snoozing_q;
  assign snooze_count = SnoozeEn ? cnt_q : '0;
  assign state_o      = state_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Randomized self-checking bench for alarm_trigger against a seconds-level
// behavioural model; follows ALARM_SNOOZE_EN the same way the design does.
module tb_alarm_trigger;

  localparam int unsigned RING = 5;
  localparam int unsigned SNZ  = 3;
  localparam int unsigned MAXS = 2;

`ifdef ALARM_SNOOZE_EN
  localparam bit SnzEn = 1'b1;
`else
  localparam bit SnzEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick, snooze, stop, alarm_on;
  logic [4:0] hours, alarm_hours;
  logic [5:0] minutes, seconds, alarm_minutes;
  logic       ring, snoozing;
  logic [1:0] snooze_count, state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit prev_tick = 1'b0;
  bit rand_time = 1'b0;

  // Model: mode 0 idle, 1 ringing, 2 snoozing, 3 locked out.
  int m_mode = 0;
  int m_left = 0;
  int m_snz  = 0;

  always #5 clk = ~clk;

  alarm_trigger #(
    .RING_SECS  (RING),
    .SNOOZE_SECS(SNZ),
    .MAX_SNOOZE (MAXS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sec_tick     (sec_tick),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes),
    .alarm_on     (alarm_on),
    .snooze       (snooze),
    .stop         (stop),
    .ring         (ring),
    .snoozing     (snoozing),
    .snooze_count (snooze_count),
    .state_o      (state_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    check_val("ring", {31'd0, ring}, (m_mode == 1) ? 1 : 0);
    check_val("snoozing", {31'd0, snoozing}, (SnzEn && m_mode == 2) ? 1 : 0);
    check_val("snooze_count", {30'd0, snooze_count}, SnzEn ? m_snz : 0);
    check_val("state", {30'd0, state_o}, m_mode);
  endtask

  // Applies one clock edge worth of the alarm rules to the model.
  task automatic model_step();
    bit match;
    bit last_sec;
    match = alarm_on && hours == alarm_hours && minutes == alarm_minutes && seconds == 0;
    last_sec = sec_tick && (m_left == 1);
    if (!reset) begin
      m_mode = 0; m_left = 0; m_snz = 0;
      return;
    end
    if (!alarm_on) begin
      m_mode = 0; m_snz = 0;
      return;
    end
    case (m_mode)
      0: if (match) begin m_mode = 1; m_left = RING; m_snz = 0; end
      1: begin
        if (stop) m_mode = 3;
        else if (SnzEn && snooze && m_snz < MAXS) begin
          m_mode = 2; m_left = SNZ; m_snz++;
        end
        else if (last_sec) m_mode = 3;
        else if (sec_tick) m_left--;
      end
      2: begin
        if (stop) m_mode = 3;
        else if (last_sec) begin m_mode = 1; m_left = RING; end
        else if (sec_tick) m_left--;
      end
      default: if (!match) m_mode = 0;
    endcase
  endtask

  task automatic tick_clock_time();
    if (seconds == 59) begin
      seconds = 0;
      if (minutes == 59) begin
        minutes = 0;
        hours = (hours >= 23) ? 5'd0 : hours + 5'd1;
      end else begin
        minutes = minutes + 6'd1;
      end
    end else begin
      seconds = seconds + 6'd1;
    end
  endtask

  task automatic advance_time();
    int r;
    if (!rand_time) begin
      tick_clock_time();
      return;
    end
    r = $urandom_range(0, 19);
    if (r < 2) begin
      hours = alarm_hours; minutes = alarm_minutes; seconds = 0;
    end else if (r == 2) begin
      hours = 5'($urandom_range(24, 31)); minutes = alarm_minutes; seconds = 0;
    end else if (r == 3) begin
      alarm_minutes = 6'($urandom_range(0, 59));
    end else begin
      tick_clock_time();
    end
  endtask

  task automatic step(input bit snz_p, input bit stop_p, input bit on_p);
    @(negedge clk);
    if (prev_tick) advance_time();
    sec_tick  = (cyc % 4 == 3);
    snooze    = snz_p;
    stop      = stop_p;
    alarm_on  = on_p;
    prev_tick = sec_tick;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
    prev_tick = 1'b0;
  endtask

  task automatic wait_ring();
    for (int i = 0; i < 40 && m_mode != 1; i++) step(1'b0, 1'b0, 1'b1);
    check_val("ring_reached", {31'd0, ring}, 1);
  endtask

  initial begin
    reset = 1'b0; sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0; alarm_on = 1'b0;
    alarm_hours = 5'd7; alarm_minutes = 6'd30;
    set_time(7, 29, 58);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Match, auto-silence and lockout release.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);

    // Stop inside the matching second holds lockout.
    set_time(7, 29, 59);
    wait_ring();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);

    // Repeated snoozes up to and past the limit.
    set_time(7, 29, 59);
    wait_ring();
    for (int i = 0; i < 120; i++) step((m_mode == 1) && ($urandom_range(0, 3) == 0), 1'b0, 1'b1);

    // Stop and snooze together.
    set_time(7, 29, 59);
    wait_ring();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);

    // Disarm while snoozing.
    set_time(7, 29, 59);
    wait_ring();
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-ring.
    set_time(7, 29, 59);
    wait_ring();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    m_mode = 0; m_left = 0; m_snz = 0;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    prev_tick = 1'b0;

    // Randomized traffic.
    rand_time = 1'b1;
    set_time(7, 29, 58);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 149) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
